// File: rtl/alu_op_issuer.sv
// alu_op_issuer: buffers ALU requests in a FIFO, drives the ALU operands and returns results over valid/ready.
module alu_op_issuer #(
  parameter int DEPTH   = 2,
  parameter int ALU_LAT = 0,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic             req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_in0,
  output logic [31:0]      alu_in1,
  output logic             alu_sel,
  input  logic [31:0]      alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_eq,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = ALU_LAT > 0 ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [1:0] IDLE = 2'd0, DRIVE = 2'd1, RESP = 2'd2;
  logic [31:0]      fa [DEPTH];
  logic [31:0]      fb [DEPTH];
  logic             fo [DEPTH];
  logic [TAG_W-1:0] ft [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      count;
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [TAG_W-1:0] cur_tag;
  logic             push, pop, empty;
  assign empty     = count == '0;
  assign req_ready = count != (AW+1)'(DEPTH);
  assign push      = req_valid && req_ready;
  // The head is taken either from idle or straight out of a completed handshake, so no idle cycle separates queued ops.
  assign pop       = !empty && (state == IDLE || (state == RESP && rsp_ready));
  assign busy      = !empty || state != IDLE;
  always_ff @(posedge clk) begin
    if (push) begin
      fa[wp] <= req_a;
      fb[wp] <= req_b;
      fo[wp] <= req_op;
      ft[wp] <= req_tag;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      state     <= IDLE;
      cnt       <= '0;
      cur_tag   <= '0;
      alu_in0   <= '0;
      alu_in1   <= '0;
      alu_sel   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_eq    <= 1'b0;
      rsp_tag   <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (state == DRIVE) begin
        if (cnt == CW'(ALU_LAT)) begin
          rsp_data  <= alu_out;
          rsp_eq    <= !alu_sel && alu_out[0];
          rsp_tag   <= cur_tag;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end else cnt <= cnt + 1'b1;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        if (!pop) state <= IDLE;
      end
      if (pop) begin
        alu_in0 <= fa[rp];
        alu_in1 <= fb[rp];
        alu_sel <= fo[rp];
        cur_tag <= ft[rp];
        cnt     <= '0;
        state   <= DRIVE;
      end
    end
  end
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: directed checks of a combinational-ALU instance and a two-cycle-ALU instance.
module tb_alu_op_issuer;
  logic clk = 0, rst = 1, rsp_ready = 1, v0 = 0, v1 = 0;
  logic [31:0] req_a = 0, req_b = 0;
  logic req_op = 0;
  logic [3:0] req_tag = 0;
  logic d0_req_ready, d0_alu_sel, d0_rsp_valid, d0_rsp_eq, d0_busy;
  logic d1_req_ready, d1_alu_sel, d1_rsp_valid, d1_rsp_eq, d1_busy;
  logic [31:0] d0_in0, d0_in1, d0_out, d0_rsp_data, d1_in0, d1_in1, d1_out, d1_rsp_data;
  logic [3:0] d0_rsp_tag, d1_rsp_tag;
  logic [31:0] p1 = 0, p2 = 0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  assign d0_out = d0_alu_sel ? d0_in0 + d0_in1 : {31'b0, d0_in0 == d0_in1};
  always @(posedge clk) begin
    p1 <= d1_alu_sel ? d1_in0 + d1_in1 : {31'b0, d1_in0 == d1_in1};
    p2 <= p1;
  end
  assign d1_out = p2;
  alu_op_issuer #(.DEPTH(2), .ALU_LAT(0), .TAG_W(4)) u0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(d0_req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_tag(req_tag), .alu_in0(d0_in0), .alu_in1(d0_in1), .alu_sel(d0_alu_sel),
    .alu_out(d0_out), .rsp_valid(d0_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(d0_rsp_data),
    .rsp_eq(d0_rsp_eq), .rsp_tag(d0_rsp_tag), .busy(d0_busy));
  alu_op_issuer #(.DEPTH(2), .ALU_LAT(2), .TAG_W(4)) u1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(d1_req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_tag(req_tag), .alu_in0(d1_in0), .alu_in1(d1_in1), .alu_sel(d1_alu_sel),
    .alu_out(d1_out), .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(d1_rsp_data),
    .rsp_eq(d1_rsp_eq), .rsp_tag(d1_rsp_tag), .busy(d1_busy));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic set_req(input logic [31:0] a, input logic [31:0] b, input logic op, input logic [3:0] tag);
    req_a = a;
    req_b = b;
    req_op = op;
    req_tag = tag;
  endtask
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [3:0] tag, input logic [31:0] ed, input logic ee);
    @(negedge clk);
    set_req(a, b, op, tag);
    v0 = 1;
    @(negedge clk);
    v0 = 0;
    check({nm, " valid_n0"}, d0_rsp_valid, 0);
    @(negedge clk);
    check({nm, " in0"}, d0_in0, a);
    check({nm, " in1"}, d0_in1, b);
    check({nm, " sel"}, d0_alu_sel, op);
    check({nm, " valid_n1"}, d0_rsp_valid, 0);
    @(negedge clk);
    check({nm, " valid_n2"}, d0_rsp_valid, 1);
    check({nm, " data"}, d0_rsp_data, ed);
    check({nm, " eq"}, d0_rsp_eq, ee);
    check({nm, " tag"}, d0_rsp_tag, tag);
    @(negedge clk);
    check({nm, " valid_done"}, d0_rsp_valid, 0);
    check({nm, " busy_done"}, d0_busy, 0);
  endtask
  initial begin
    int k;
    int seen;
    logic [3:0] got_tag [8];
    logic [31:0] got_data [8];
    int at_cyc [8];
    repeat (2) @(negedge clk);
    check("rst valid", d0_rsp_valid, 0);
    check("rst ready", d0_req_ready, 1);
    check("rst busy", d0_busy, 0);
    check("rst in0", d0_in0, 0);
    check("rst sel", d0_alu_sel, 0);
    rst = 0;
    // Reset while the latency-2 instance is mid-drive with two more ops queued.
    set_req(1, 1, 1, 9);
    v1 = 1;
    @(negedge clk);
    set_req(2, 2, 1, 10);
    @(negedge clk);
    set_req(3, 3, 1, 11);
    @(negedge clk);
    v1 = 0;
    check("mid full", d1_req_ready, 0);
    check("mid busy", d1_busy, 1);
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    check("rst2 valid", d1_rsp_valid, 0);
    check("rst2 ready", d1_req_ready, 1);
    check("rst2 busy", d1_busy, 0);
    check("rst2 sel", d1_alu_sel, 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (d1_rsp_valid) seen++;
    end
    check("rst2 dropped", seen, 0);
    run_op("add", 32'h5, 32'h7, 1, 3, 32'hC, 0);
    run_op("wrap", 32'hFFFF_FFFF, 32'h2, 1, 4, 32'h1, 0);
    run_op("cmp_eq", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 5, 32'h1, 1);
    run_op("cmp_ne", 32'h1, 32'h2, 0, 6, 32'h0, 0);
    // Backpressure: three ops fill the block, a fourth must be refused.
    @(negedge clk);
    rsp_ready = 0;
    set_req(0, 1, 1, 0);
    v0 = 1;
    @(negedge clk);
    set_req(16, 1, 1, 1);
    @(negedge clk);
    set_req(32, 1, 1, 2);
    @(negedge clk);
    set_req(48, 1, 1, 3);
    check("bp ready", d0_req_ready, 0);
    check("bp valid", d0_rsp_valid, 1);
    check("bp tag", d0_rsp_tag, 0);
    repeat (3) begin
      @(negedge clk);
      check("bp hold ready", d0_req_ready, 0);
      check("bp hold valid", d0_rsp_valid, 1);
      check("bp hold tag", d0_rsp_tag, 0);
      check("bp hold data", d0_rsp_data, 1);
    end
    v0 = 0;
    rsp_ready = 1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (d0_rsp_valid && k < 8) begin
        got_tag[k] = d0_rsp_tag;
        got_data[k] = d0_rsp_data;
        at_cyc[k] = i;
        k++;
      end
      @(negedge clk);
    end
    check("bp count", k, 3);
    for (int j = 0; j < 3 && j < k; j++) begin
      check("bp order tag", got_tag[j], j);
      check("bp order data", got_data[j], 32'(j * 16 + 1));
      check("bp spacing", at_cyc[j], j * 2);
    end
    check("bp busy end", d0_busy, 0);
    // Latency-2 ALU: result must be sampled three edges after operands are driven.
    set_req(100, 23, 1, 5);
    v1 = 1;
    @(negedge clk);
    v1 = 0;
    @(negedge clk);
    check("lat2 in0", d1_in0, 100);
    check("lat2 valid n1", d1_rsp_valid, 0);
    @(negedge clk);
    check("lat2 valid n2", d1_rsp_valid, 0);
    @(negedge clk);
    check("lat2 valid n3", d1_rsp_valid, 0);
    @(negedge clk);
    check("lat2 valid n4", d1_rsp_valid, 1);
    check("lat2 data", d1_rsp_data, 123);
    check("lat2 eq", d1_rsp_eq, 0);
    check("lat2 tag", d1_rsp_tag, 5);
    check("lat2 hold in0", d1_in0, 100);
    @(negedge clk);
    check("lat2 done", d1_rsp_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
